// File: rtl/uart_frame_tx_if.sv
// Sample strobe input and byte-transmitter start/busy handshake for uart_frame_tx.
interface uart_frame_tx_if #(
   parameter int SAMPLE_W = 12
);
   logic [SAMPLE_W-1:0] sample_data;
   logic                sample_valid;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_busy;

   modport master (
      input  sample_data,
      input  sample_valid,
      output tx_start,
      output tx_data,
      input  tx_busy
   );

   modport slave (
      output sample_data,
      output sample_valid,
      input  tx_start,
      input  tx_data,
      output tx_busy
   );
endinterface

// File: rtl/uart_frame_tx.sv
// Buffers ADC samples and emits each as a 5-byte frame (sync, seq, hi, lo, checksum)
// to a byte UART transmitter over a start/busy handshake, with an idle gap after every frame.
module uart_frame_tx #(
   parameter int         SAMPLE_W   = 12,
   parameter int         DEPTH      = 4,
   parameter int         GAP_CYCLES = 2,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic            uart_frame_bclk,
   input  logic            uart_frame_rst,
   uart_frame_tx_if.master bus,
   output logic            frame_active,
   output logic            fifo_full,
   output logic            overflow,
   input  logic            overflow_clr
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(GAP_CYCLES + 2);
   localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT, S_GAP} state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       cnt_q, cnt_d;
   logic [2:0]          idx_q, idx_d;
   logic [7:0]          seq_q, seq_d;
   logic [4:0][7:0]     frame_q, frame_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                frame_active_q, frame_active_d;
   logic                overflow_q, overflow_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [SAMPLE_W-1:0] mem_q [DEPTH];

   logic                pop, push;
   logic [15:0]         sample16;
   logic [2:0]          idx_nxt;

   // A full FIFO still accepts a sample on the cycle it is being popped.
   assign pop     = (state_q == S_IDLE) && (count_q != '0);
   assign push    = bus.sample_valid && ((count_q != CW'(DEPTH)) || pop);
   assign idx_nxt = idx_q + 3'd1;

   always_comb begin
      sample16                 = '0;
      sample16[SAMPLE_W-1:0]   = mem_q[rd_ptr_q];
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
      overflow_d = overflow_q;
      if (overflow_clr) begin
         overflow_d = 1'b0;
      end
      if (bus.sample_valid && !push) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      seq_d          = seq_q;
      frame_d        = frame_q;
      tx_data_d      = tx_data_q;
      frame_active_d = frame_active_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               frame_d[0]     = SYNC_BYTE;
               frame_d[1]     = seq_q;
               frame_d[2]     = sample16[15:8];
               frame_d[3]     = sample16[7:0];
               frame_d[4]     = seq_q + sample16[15:8] + sample16[7:0];
               idx_d          = 3'd0;
               tx_data_d      = SYNC_BYTE;
               frame_active_d = 1'b1;
               state_d        = S_SEND;
            end
         end
         S_SEND: begin
            cnt_d   = '0;
            state_d = S_GUARD;
         end
         // Busy from the transmitter is registered and may lag the start pulse.
         S_GUARD: begin
            if (cnt_q == TW'(1)) begin
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_WAIT: begin
            if (!bus.tx_busy) begin
               if (idx_q != 3'd4) begin
                  idx_d     = idx_nxt;
                  tx_data_d = frame_q[idx_nxt];
                  state_d   = S_SEND;
               end else begin
                  seq_d = seq_q + 8'd1;
                  cnt_d = '0;
                  if (GAP_CYCLES == 0) begin
                     frame_active_d = 1'b0;
                     state_d        = S_IDLE;
                  end else begin
                     state_d = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               frame_active_d = 1'b0;
               state_d        = S_IDLE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge uart_frame_bclk) begin
      if (uart_frame_rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         idx_q          <= 3'd0;
         seq_q          <= 8'd0;
         frame_q        <= '0;
         tx_data_q      <= 8'h00;
         frame_active_q <= 1'b0;
         overflow_q     <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         seq_q          <= seq_d;
         frame_q        <= frame_d;
         tx_data_q      <= tx_data_d;
         frame_active_q <= frame_active_d;
         overflow_q     <= overflow_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
      end
   end

   always_ff @(posedge uart_frame_bclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.sample_data;
      end
   end

   assign bus.tx_start = (state_q == S_SEND);
   assign bus.tx_data  = tx_data_q;
   assign frame_active = frame_active_q;
   assign fifo_full    = (count_q == CW'(DEPTH));
   assign overflow     = overflow_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: fixed frame vectors, random frames against a frame-level
// model, and hand-written overflow, reset-in-frame and busy-tied-low sequences.
module tb_uart_frame_tx;
   localparam int SAMPLE_W   = 12;
   localparam int DEPTH      = 4;
   localparam int GAP_CYCLES = 2;

   logic clk = 1'b0;
   logic rst;
   logic frame_active, fifo_full, overflow, overflow_clr;

   uart_frame_tx_if #(.SAMPLE_W(SAMPLE_W)) bif ();

   uart_frame_tx #(
      .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .SYNC_BYTE(8'hA5)
   ) dut (
      .uart_frame_bclk(clk),
      .uart_frame_rst (rst),
      .bus            (bif.master),
      .frame_active   (frame_active),
      .fifo_full      (fifo_full),
      .overflow       (overflow),
      .overflow_clr   (overflow_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SAMPLE_W-1:0] smp;
      logic [39:0]         bytes;
   } vec_t;
   vec_t tbl [4];

   int         checks   = 0;
   int         errors   = 0;
   int         tick_n   = 0;
   int         timeouts = 0;
   logic [7:0] cap_q [$];
   int         cap_t [$];
   logic [7:0] exp_q [$];
   int         exp_seq;
   logic       busy_mode, busy_force, stab_en, prev_start;
   logic [7:0] cur_byte;
   int         rise_in, high_left;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: observe outputs at the falling edge, then update the transmitter model.
   task automatic tick();
      @(negedge clk);
      tick_n++;
      if (bif.tx_start === 1'b1) begin
         check("start_single_cycle", {31'd0, prev_start}, 32'd0);
         cap_q.push_back(bif.tx_data);
         cap_t.push_back(tick_n);
         cur_byte  = bif.tx_data;
         rise_in   = $urandom_range(2, 1);
         high_left = $urandom_range(8, 1);
      end
      if (stab_en && bif.tx_busy === 1'b1) begin
         check("tx_data_stable", {24'd0, bif.tx_data}, {24'd0, cur_byte});
      end
      prev_start = bif.tx_start;
      if (busy_mode) begin
         bif.tx_busy = busy_force;
      end else if (rise_in > 0) begin
         rise_in--;
         if (rise_in == 0) bif.tx_busy = 1'b1;
      end else if (bif.tx_busy && high_left > 0) begin
         high_left--;
         if (high_left == 0) bif.tx_busy = 1'b0;
      end
   endtask

   task automatic set_auto_busy();
      busy_mode   = 1'b0;
      rise_in     = 0;
      high_left   = 0;
      bif.tx_busy = 1'b0;
   endtask

   task automatic send(input logic [SAMPLE_W-1:0] smp, output int vt);
      bif.sample_data  = smp;
      bif.sample_valid = 1'b1;
      vt = tick_n;
      tick();
      bif.sample_valid = 1'b0;
   endtask

   task automatic push_frame(input logic [SAMPLE_W-1:0] smp);
      int s16, hi, lo;
      s16 = int'(smp);
      hi  = s16 / 256;
      lo  = s16 % 256;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(exp_seq));
      exp_q.push_back(8'(hi));
      exp_q.push_back(8'(lo));
      exp_q.push_back(8'((exp_seq + hi + lo) % 256));
      exp_seq = (exp_seq + 1) % 256;
   endtask

   task automatic get_byte(input string name, output logic [7:0] b, output int t);
      int n     = 0;
      int limit = (timeouts >= 3) ? 0 : 400;
      while (cap_q.size() == 0 && n < limit) begin
         tick();
         n++;
      end
      if (cap_q.size() == 0) begin
         checks++;
         errors++;
         timeouts++;
         $display("FAIL %s: no start pulse within %0d cycles", name, limit);
         b = 8'h00;
         t = 0;
      end else begin
         b = cap_q.pop_front();
         t = cap_t.pop_front();
      end
   endtask

   task automatic drain(input string name);
      logic [7:0] b, e;
      int         t;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         get_byte(name, b, t);
         check(name, {24'd0, b}, {24'd0, e});
      end
   endtask

   task automatic random_phase(input int frames);
      int remaining = frames;
      int burst, vt;
      logic [SAMPLE_W-1:0] r;
      while (remaining > 0) begin
         burst = $urandom_range(4, 1);
         if (burst > remaining) burst = remaining;
         for (int k = 0; k < burst; k++) begin
            r = SAMPLE_W'($urandom);
            send(r, vt);
            push_frame(r);
            repeat ($urandom_range(2, 0)) tick();
         end
         remaining -= burst;
         drain("rand_byte");
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]          b;
      logic [39:0]         v;
      logic [SAMPLE_W-1:0] smp;
      int                  t, vt, n;
      int                  st [5];

      tbl[0] = '{12'hABC, 40'hA5_00_0A_BC_C6};
      tbl[1] = '{12'h123, 40'hA5_01_01_23_25};
      tbl[2] = '{12'h000, 40'hA5_FF_00_00_FF};
      tbl[3] = '{12'h001, 40'hA5_00_00_01_01};

      bif.sample_data  = '0;
      bif.sample_valid = 1'b0;
      bif.tx_busy      = 1'b0;
      overflow_clr     = 1'b0;
      busy_force       = 1'b0;
      stab_en          = 1'b0;
      prev_start       = 1'b0;
      cur_byte         = 8'h00;
      exp_seq          = 0;
      set_auto_busy();

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_tx_start", {31'd0, bif.tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, bif.tx_data}, 32'd0);
      check("rst_frame_active", {31'd0, frame_active}, 32'd0);
      check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      stab_en = 1'b1;

      // Fixed vectors; 253 random frames in between walk the sequence number up to FF.
      for (int i = 0; i < 4; i++) begin
         if (i == 2) random_phase(253);
         send(tbl[i].smp, vt);
         for (int j = 0; j < 5; j++) begin
            get_byte($sformatf("tbl%0d_b%0d", i, j), b, t);
            v = tbl[i].bytes;
            check($sformatf("tbl%0d_b%0d", i, j), {24'd0, b}, {24'd0, v[39-8*j -: 8]});
            if (i == 0 && j == 0) check("latency_valid_to_start", t - vt, 32'd2);
         end
         exp_seq = (exp_seq + 1) % 256;
      end

      // Overflow: hold the first frame in WAIT while six samples arrive back to back.
      repeat (20) tick();
      busy_mode  = 1'b1;
      busy_force = 1'b1;
      repeat (2) tick();
      for (int k = 0; k < 6; k++) begin
         smp = SAMPLE_W'($urandom);
         send(smp, vt);
         if (k < 5) push_frame(smp);
      end
      check("ovf_set", {31'd0, overflow}, 32'd1);
      check("ovf_fifo_full", {31'd0, fifo_full}, 32'd1);
      bif.sample_data  = SAMPLE_W'($urandom);
      bif.sample_valid = 1'b1;
      overflow_clr     = 1'b1;
      tick();
      bif.sample_valid = 1'b0;
      overflow_clr     = 1'b0;
      check("ovf_set_wins_over_clr", {31'd0, overflow}, 32'd1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("ovf_clr", {31'd0, overflow}, 32'd0);
      check("ovf_full_still", {31'd0, fifo_full}, 32'd1);

      // Push on the same edge as an IDLE pop from a full FIFO.
      set_auto_busy();
      n = 0;
      while (frame_active !== 1'b0 && n < 2000) begin
         tick();
         n++;
      end
      check("pop_edge_idle_reached", {31'd0, frame_active}, 32'd0);
      smp = SAMPLE_W'($urandom);
      send(smp, vt);
      push_frame(smp);
      check("pop_push_no_overflow", {31'd0, overflow}, 32'd0);
      check("pop_push_count_full", {31'd0, fifo_full}, 32'd1);
      drain("ovf_frame_byte");

      // Reset while waiting on busy for byte B2, with another sample buffered.
      repeat (20) tick();
      smp = SAMPLE_W'($urandom);
      send(smp, vt);
      push_frame(smp);
      for (int j = 0; j < 3; j++) begin
         get_byte("rstf_byte", b, t);
         check($sformatf("rstf_b%0d", j), {24'd0, b}, {24'd0, exp_q.pop_front()});
      end
      busy_mode  = 1'b1;
      busy_force = 1'b1;
      send(SAMPLE_W'($urandom), vt);
      repeat (3) tick();
      stab_en = 1'b0;
      rst     = 1'b1;
      tick();
      rst = 1'b0;
      check("rstf_tx_start", {31'd0, bif.tx_start}, 32'd0);
      check("rstf_tx_data", {24'd0, bif.tx_data}, 32'd0);
      check("rstf_frame_active", {31'd0, frame_active}, 32'd0);
      check("rstf_fifo_full", {31'd0, fifo_full}, 32'd0);
      exp_q.delete();
      cap_q.delete();
      cap_t.delete();
      exp_seq  = 0;
      cur_byte = 8'h00;
      set_auto_busy();
      stab_en = 1'b1;
      repeat (15) tick();
      check("rstf_fifo_emptied", cap_q.size(), 32'd0);
      smp = SAMPLE_W'($urandom);
      send(smp, vt);
      push_frame(smp);
      drain("rstf_new_frame");

      // Busy tied low: starts every 4 cycles, gap then idle.
      repeat (20) tick();
      busy_mode  = 1'b1;
      busy_force = 1'b0;
      smp = SAMPLE_W'($urandom);
      send(smp, vt);
      push_frame(smp);
      for (int j = 0; j < 5; j++) begin
         get_byte("low_byte", b, t);
         st[j] = t;
         check($sformatf("low_b%0d", j), {24'd0, b}, {24'd0, exp_q.pop_front()});
         if (j == 0) check("low_frame_active_in_frame", {31'd0, frame_active}, 32'd1);
      end
      for (int j = 1; j < 5; j++) begin
         check($sformatf("low_spacing_%0d", j), st[j] - st[j-1], 32'd4);
      end
      n = 0;
      while (frame_active !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      check("low_frame_active_drop", tick_n - st[4], 32'(4 + GAP_CYCLES));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Upstream feeder for the byte-level UART transmitter.
- Accepts ADC samples on a valid strobe and buffers them in a small FIFO.
- Turns each sample into a fixed 5-byte frame (sync, sequence, sample high byte, sample low byte, checksum).
- Hands the frame to the transmitter one byte at a time over a start/busy handshake. Runs on the UART bit clock, so the transmitter and this block share one clock domain.

Parameters:
SAMPLE_W, 12, ADC sample width (1..16); zero-extended to 16 bits for framing.
DEPTH, 4, FIFO depth in samples; power of 2, at least 2.
GAP_CYCLES, 2, idle bit-clock cycles inserted after each frame; 0 means no gap.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
uart_frame_bclk  in  1  UART bit clock; all logic on the rising edge.
uart_frame_rst  in  1  Synchronous, active-high reset.
sample_data  in  SAMPLE_W  ADC sample.
sample_valid  in  1  One-cycle strobe; sample_data is captured on that edge.
tx_start  out  1  One-cycle start pulse to the transmitter.
tx_data  out  8  Byte to the transmitter; held stable from the start pulse until busy falls.
tx_busy  in  1  Transmitter busy flag.
frame_active  out  1  High from the FIFO pop through the end of the gap.
fifo_full  out  1  FIFO count equals DEPTH.
overflow  out  1  Sticky sample-drop flag.
overflow_clr  in  1  Clears overflow; set wins if both happen in the same cycle.

Behaviour:
- Reset (synchronous, active-high), applied at the next edge:
  - Outputs: tx_start=0, tx_data=8'h00, frame_active=0, fifo_full=0, overflow=0.
  - Internal: FIFO emptied, sequence counter=0, state=IDLE, byte index=0.
  - Reset during a frame abandons it immediately. No further start pulses are issued. A byte already in the transmitter is not aborted by this block.
- FIFO:
  - Push on sample_valid when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
  - Pop only in IDLE. Read and write pointers wrap modulo DEPTH.
- Frame bytes are latched at pop: B0=SYNC_BYTE, B1=seq, B2=sample16[15:8], B3=sample16[7:0], B4=(B1+B2+B3) mod 256.
- The sequence counter is 8 bits and increments after B4 completes; it wraps 8'hFF to 8'h00.
- State machine:
  - IDLE: if FIFO non-empty, pop, latch bytes, index=0, tx_data<=B0, go to SEND; else stay.
  - SEND: tx_start=1 for exactly this cycle, tx_data=B[index]; go to GUARD.
  - GUARD: 2 cycles with tx_busy ignored. This covers the transmitter's registered busy rising 1-2 cycles after the start pulse. Then go to WAIT.
  - WAIT: stay while tx_busy=1. On tx_busy=0: if index<4, index+1, tx_data<=B[index+1], go to SEND; else seq+1 and go to GAP (or IDLE if GAP_CYCLES=0).
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- tx_data changes only on the edge that enters SEND, or on reset.
- frame_active is set on the pop edge and cleared on the edge that enters IDLE.
- Latency: sample_valid at edge 0 with an empty FIFO and IDLE state gives tx_start=1 and tx_data=SYNC_BYTE in cycle 2.
- Start-to-start spacing is at least 4 cycles per byte (SEND, 2x GUARD, WAIT).
- tx_busy X or low after reset has no effect until the first GUARD/WAIT.

Test Plan:
- Single sample 12'hABC after reset; the bench models the transmitter with busy high 2..10 cycles after start -> bytes A5,00,0A,BC,C6, one start pulse each, tx_data stable while busy is high, frame_active drops 2 cycles after the last busy fall.
- Second sample 12'h123 -> A5,01,01,23,25; then force seq=FF with sample 12'h000 -> A5,FF,00,00,FF, and the next frame carries seq 00.
- Six back-to-back valids (DEPTH=4) while the first frame is held in WAIT by tx_busy=1 -> first sample in flight plus 4 buffered, sixth dropped, overflow=1 and fifo_full=1. Five frames follow in order; overflow_clr then clears overflow.
- sample_valid on the same edge as an IDLE pop with a full FIFO -> sample accepted, no overflow, count stays DEPTH.
- Reset asserted in WAIT of byte B2 -> next cycle tx_start=0, tx_data=00, frame_active=0, FIFO empty; a new sample then produces a frame with seq 00.
- tx_busy tied low -> each byte still gets a start pulse followed by exactly 2 GUARD cycles; consecutive starts are 4 cycles apart.
